irq_request_capture: RTL and testbench

Clocked, parametrised interrupt request register for the PIC datapath. Supersedes the combinational request stage: synchronises `NUM_IRQ` asynchronous request pins, applies per-channel edge or level sensing with 8259A-style re-arm rules, and holds the Interrupt Request Register (IRR). Sits between the IR pins and the priority resolver. Supports a freeze window during the INTA sequence and per-bit clear on acknowledge.

---
 rtl/pic_pkg.sv | 20 ++
 rtl/irq_channel.sv | 101 ++++++++++
 rtl/irq_request_capture.sv | 78 +++++++
 tb/tb_irq_request_capture.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared constants and helpers for the PIC request-capture datapath.
package pic_pkg;

    // Channel count used when no override is given.
    localparam int NUM_IRQ_DEFAULT = 8;

    // Trig_Mode encoding per channel.
    localparam logic TRIG_EDGE  = 1'b0;
    localparam logic TRIG_LEVEL = 1'b1;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int idx_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage : pic_pkg

// File: rtl/irq_channel.sv
// One interrupt request channel: pin synchroniser, edge re-arm flag and IRR bit.
module irq_channel
    import pic_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    input  logic trig_mode_i,
    input  logic init_i,
    input  logic freeze_i,
    input  logic clr_i,
    output logic irr_o,
    output logic irr_next_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    // Marks which synchroniser stages hold real pin samples since reset.
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   armed_q;
    logic                   armed_d;
    logic                   irr_q;
    logic                   irr_d;
    logic                   s_s;
    logic                   fill_done_s;
    logic                   capture_s;

    assign s_s         = sync_q[SYNC_STAGES-1];
    assign fill_done_s = fill_q[SYNC_STAGES-1];

    // Synchronise the raw pin and track when the chain holds genuine samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            fill_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Edge capture only when unfrozen, in edge mode, with a high sample on an armed channel.
    always_comb begin
        capture_s = 1'b0;
        if ((trig_mode_i == TRIG_EDGE) && !freeze_i && s_s && armed_q) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end
    end

    // Re-arm on a genuine low sample; a reset-time zero in the chain must not arm.
    always_comb begin
        armed_d = armed_q;
        if (init_i) begin
            armed_d = 1'b0;
        end else if (capture_s) begin
            armed_d = 1'b0;
        end else if (!s_s && fill_done_s) begin
            armed_d = 1'b1;
        end else begin
            armed_d = armed_q;
        end
    end

    // IRR next state: init, then clear, then freeze hold, then mode-specific sensing.
    always_comb begin
        irr_d = irr_q;
        if (init_i) begin
            irr_d = 1'b0;
        end else if (clr_i) begin
            irr_d = 1'b0;
        end else if (freeze_i) begin
            irr_d = irr_q;
        end else if (trig_mode_i == TRIG_LEVEL) begin
            irr_d = s_s;
        end else if (capture_s) begin
            irr_d = 1'b1;
        end else if (!s_s) begin
            irr_d = 1'b0;
        end else begin
            irr_d = irr_q;
        end
    end

    // Register the arm flag and the IRR bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
            irr_q   <= 1'b0;
        end else begin
            armed_q <= armed_d;
            irr_q   <= irr_d;
        end
    end

    assign irr_o      = irr_q;
    assign irr_next_o = irr_d;

endmodule : irq_channel

// File: rtl/irq_request_capture.sv
// Interrupt Request Register: per-channel capture, acknowledge clear decode and pending flag.
module irq_request_capture
    import pic_pkg::*;
#(
    parameter int NUM_IRQ     = NUM_IRQ_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int IDX_W       = idx_width(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] Int_Req_Pins,
    input  logic [NUM_IRQ-1:0] Trig_Mode,
    input  logic               Init,
    input  logic               Freeze,
    input  logic               Clr_Valid,
    input  logic [IDX_W-1:0]   Clr_Index,
    output logic [NUM_IRQ-1:0] Int_Req_Reg,
    output logic               Int_Pending
);

    logic [NUM_IRQ-1:0] clr_vec_s;
    logic [NUM_IRQ-1:0] irr_next_s;
    logic [31:0]        clr_idx_ext_s;
    logic               pending_q;
    logic               pending_d;

    assign clr_idx_ext_s = 32'(Clr_Index);

    // One-hot clear decode; indices at or above NUM_IRQ select nothing.
    always_comb begin
        clr_vec_s = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (Clr_Valid && (clr_idx_ext_s == 32'(i))) begin
                clr_vec_s[i] = 1'b1;
            end else begin
                clr_vec_s[i] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_chan
        irq_channel #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .pin_i       (Int_Req_Pins[g]),
            .trig_mode_i (Trig_Mode[g]),
            .init_i      (Init),
            .freeze_i    (Freeze),
            .clr_i       (clr_vec_s[g]),
            .irr_o       (Int_Req_Reg[g]),
            .irr_next_o  (irr_next_s[g])
        );
    end

    // Pending is built from the IRR next state so it moves on the same edge as IRR.
    always_comb begin
        pending_d = 1'b0;
        if (|irr_next_s) begin
            pending_d = 1'b1;
        end else begin
            pending_d = 1'b0;
        end
    end

    // Register the pending flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign Int_Pending = pending_q;

endmodule : irq_request_capture

// File: tb/tb_irq_request_capture.sv
// Directed bench for irq_request_capture with a small expectation scoreboard.
module tb_irq_request_capture;

    logic        clk;
    logic        rst_n;

    // Instance A: 8 channels, 2-stage sync, widened index so out-of-range values are expressible.
    logic [7:0]  a_pins;
    logic [7:0]  a_mode;
    logic        a_init;
    logic        a_freeze;
    logic        a_clr_v;
    logic [3:0]  a_clr_idx;
    logic [7:0]  a_irr;
    logic        a_pend;

    // Instance B: 16 channels, 3-stage sync.
    logic [15:0] b_pins;
    logic [15:0] b_mode;
    logic        b_init;
    logic        b_freeze;
    logic        b_clr_v;
    logic [3:0]  b_clr_idx;
    logic [15:0] b_irr;
    logic        b_pend;

    typedef struct {
        bit          is_b;
        logic [15:0] irr;
        logic        pend;
    } exp_t;

    exp_t sb_q[$];
    int   total_cnt;
    int   pass_cnt;

    irq_request_capture #(
        .NUM_IRQ     (8),
        .SYNC_STAGES (2),
        .IDX_W       (4)
    ) dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .Int_Req_Pins (a_pins),
        .Trig_Mode    (a_mode),
        .Init         (a_init),
        .Freeze       (a_freeze),
        .Clr_Valid    (a_clr_v),
        .Clr_Index    (a_clr_idx),
        .Int_Req_Reg  (a_irr),
        .Int_Pending  (a_pend)
    );

    irq_request_capture #(
        .NUM_IRQ     (16),
        .SYNC_STAGES (3)
    ) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .Int_Req_Pins (b_pins),
        .Trig_Mode    (b_mode),
        .Init         (b_init),
        .Freeze       (b_freeze),
        .Clr_Valid    (b_clr_v),
        .Clr_Index    (b_clr_idx),
        .Int_Req_Reg  (b_irr),
        .Int_Pending  (b_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n active edges; inputs are driven and outputs sampled on the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Record what the chosen instance should show now, then retire it against the DUT.
    task automatic chk(input string tag, input bit is_b, input logic [15:0] e_irr, input logic e_pend);
        exp_t        e;
        logic [16:0] obs;
        logic [16:0] expv;
        sb_q.push_back('{is_b: is_b, irr: e_irr, pend: e_pend});
        total_cnt++;
        if (sb_q.size() == 0) begin
            $error("FAIL %s: observed empty scoreboard expected one entry", tag);
        end else begin
            e    = sb_q.pop_front();
            obs  = e.is_b ? {b_pend, b_irr} : {a_pend, 8'h00, a_irr};
            expv = {e.pend, e.irr};
            assert (obs === expv) pass_cnt++;
            else $error("FAIL %s: observed pend/irr=%h expected %h", tag, obs, expv);
        end
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        rst_n     = 1'b0;
        a_pins = 8'h01;  a_mode = 8'h00; a_init = 1'b0; a_freeze = 1'b0; a_clr_v = 1'b0; a_clr_idx = 4'd0;
        b_pins = 16'h0000; b_mode = 16'h0000; b_init = 1'b0; b_freeze = 1'b0; b_clr_v = 1'b0; b_clr_idx = 4'd0;

        // Reset state
        tick(3);
        chk("reset_a", 1'b0, 16'h0000, 1'b0);
        chk("reset_b", 1'b1, 16'h0000, 1'b0);
        rst_n = 1'b1;

        // Edge pin high through reset must not capture
        tick(5);
        chk("no_capture_after_reset", 1'b0, 16'h0000, 1'b0);
        a_pins = 8'h00;
        tick(3);
        a_pins = 8'h01;
        tick(3);
        chk("first_edge_after_low", 1'b0, 16'h0001, 1'b1);

        // Level mode follows pins with three-edge latency
        a_mode = 8'hFF;
        a_pins = 8'hAA;
        tick(2);
        chk("level_latency_minus1", 1'b0, 16'h0001, 1'b1);
        tick(1);
        chk("level_aa", 1'b0, 16'h00AA, 1'b1);
        a_pins = 8'h00;
        tick(3);
        chk("level_00", 1'b0, 16'h0000, 1'b0);

        // Edge capture, clear with pin high, re-arm
        a_mode = 8'h00;
        a_init = 1'b1;
        tick(1);
        a_init = 1'b0;
        a_pins = 8'h55;
        tick(3);
        chk("edge_55", 1'b0, 16'h0055, 1'b1);
        a_clr_v = 1'b1; a_clr_idx = 4'd0;
        tick(1);
        a_clr_v = 1'b0;
        chk("clr0", 1'b0, 16'h0054, 1'b1);
        tick(3);
        chk("clr0_no_recapture", 1'b0, 16'h0054, 1'b1);
        a_pins = 8'h54;
        tick(3);
        a_pins = 8'h55;
        tick(3);
        chk("rearm0", 1'b0, 16'h0055, 1'b1);

        // Withdrawal: pin3 high four cycles then low
        a_pins = 8'h5D;
        tick(3);
        chk("pin3_set", 1'b0, 16'h005D, 1'b1);
        tick(1);
        a_pins = 8'h55;
        tick(2);
        chk("pin3_fall_minus1", 1'b0, 16'h005D, 1'b1);
        tick(1);
        chk("pin3_withdrawn", 1'b0, 16'h0055, 1'b1);

        // Freeze: channel 1 level, others edge
        a_mode = 8'h02;
        a_init = 1'b1;
        a_pins = 8'h00;
        tick(1);
        a_init = 1'b0;
        chk("init_before_freeze", 1'b0, 16'h0000, 1'b0);
        tick(3);
        a_pins = 8'h01;
        tick(3);
        chk("pre_freeze_01", 1'b0, 16'h0001, 1'b1);
        a_freeze = 1'b1;
        tick(1);
        a_pins = 8'h22;
        tick(4);
        chk("frozen_hold_1", 1'b0, 16'h0001, 1'b1);
        a_pins = 8'h20;
        tick(3);
        chk("frozen_hold_2", 1'b0, 16'h0001, 1'b1);
        a_freeze = 1'b0;
        tick(1);
        chk("freeze_release", 1'b0, 16'h0020, 1'b1);

        // Simultaneous clear and edge on channel 2; out-of-range clear
        a_pins = 8'h24;
        tick(2);
        a_clr_v = 1'b1; a_clr_idx = 4'd2;
        tick(1);
        chk("clr_beats_capture", 1'b0, 16'h0020, 1'b1);
        a_clr_v = 1'b0;
        tick(3);
        chk("clr_capture_stays", 1'b0, 16'h0020, 1'b1);
        a_clr_v = 1'b1; a_clr_idx = 4'd9;
        tick(1);
        chk("clr_out_of_range", 1'b0, 16'h0020, 1'b1);
        a_clr_idx = 4'd5;
        tick(1);
        a_clr_v = 1'b0;
        chk("clr5_pending_low", 1'b0, 16'h0000, 1'b0);

        // Init with pins held high
        a_mode = 8'h00;
        a_pins = 8'h00;
        a_init = 1'b1;
        tick(1);
        a_init = 1'b0;
        tick(3);
        a_pins = 8'hFF;
        tick(3);
        chk("all_ff", 1'b0, 16'h00FF, 1'b1);
        a_init = 1'b1;
        tick(1);
        a_init = 1'b0;
        chk("init_clears", 1'b0, 16'h0000, 1'b0);
        tick(4);
        chk("init_no_recapture", 1'b0, 16'h0000, 1'b0);
        a_pins = 8'h7F;
        tick(3);
        a_pins = 8'hFF;
        tick(3);
        chk("init_toggle7", 1'b0, 16'h0080, 1'b1);

        // Wider instance: four-edge latency and init behaviour
        b_pins = 16'hFFFF;
        tick(3);
        chk("b_latency_minus1", 1'b1, 16'h0000, 1'b0);
        tick(1);
        chk("b_latency4", 1'b1, 16'hFFFF, 1'b1);
        b_init = 1'b1;
        tick(1);
        b_init = 1'b0;
        chk("b_init", 1'b1, 16'h0000, 1'b0);
        tick(5);
        chk("b_init_hold", 1'b1, 16'h0000, 1'b0);
        b_pins = 16'hFFFE;
        tick(4);
        b_pins = 16'hFFFF;
        tick(3);
        chk("b_rearm_minus1", 1'b1, 16'h0000, 1'b0);
        tick(1);
        chk("b_rearm0", 1'b1, 16'h0001, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_irq_request_capture
